// File: rtl/wdt_multi_axil.sv
// wdt_multi_axil: NCH independent watchdog channels behind an AXI4-Lite slave.
// Channel ch registers live at ch*0x10 (CTRL, KICK, TOCNT, STATUS); SUMMARY at 0x100.
// Optional build macro WDT_PRESCALE_EN adds a shared 16-bit tick prescaler (PRE) at 0x104;
// without it every clock is a tick and 0x104 is unmapped.
module wdt_multi_axil #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     AWADDR,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [31:0]     WDATA,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [31:0]     ARADDR,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [31:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RVALID,
  input  logic            RREADY,
  output logic [NCH-1:0]  WTO
);

  typedef enum logic [1:0] {StIdle, StBrsp, StRrsp} state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  state_e           state_q, state_d;
  logic             wr_acc, rd_acc;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;

  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] tocnt_q [NCH];
  logic [NCH-1:0]   en_q, wto_q;
  logic             tick;

  logic [8:0]       wa, ra;
  logic [3:0]       wch, rch;
  logic             w_chan_ok, r_chan_ok;
  logic             wr_ok, rd_ok;
  logic [31:0]      rd_val;
  logic [NCH-1:0]   ctrl_we, kick_we, tocnt_we, stat_clr;

  // Only the low nine address bits are decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[31:9], ARADDR[31:9]};

`ifdef WDT_PRESCALE_EN
  logic             pre_we;
  logic [15:0]      pre_q, pre_cnt_q;
`endif

  // Handshake: a full AW+W pair always beats a concurrent read request.
  assign AWREADY = (state_q == StIdle) && AWVALID && WVALID;
  assign WREADY  = AWREADY;
  assign ARREADY = (state_q == StIdle) && ARVALID && !(AWVALID && WVALID);
  assign wr_acc  = AWREADY;
  assign rd_acc  = ARREADY;

  assign BVALID  = (state_q == StBrsp);
  assign RVALID  = (state_q == StRrsp);
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign WTO     = wto_q;

  // Write address decode into per-channel strobes, qualified by acceptance.
  always_comb begin
    wa        = AWADDR[8:0];
    wch       = wa[7:4];
    w_chan_ok = !wa[8] && ({28'b0, wch} < NCH) && (wa[1:0] == 2'b00);
    wr_ok     = 1'b0;
    ctrl_we   = '0;
    kick_we   = '0;
    tocnt_we  = '0;
    stat_clr  = '0;
`ifdef WDT_PRESCALE_EN
    pre_we    = 1'b0;
`endif
    if (w_chan_ok) begin
      wr_ok = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (wch == 4'(i)) begin
          case (wa[3:2])
            2'd0:    ctrl_we[i]  = wr_acc;
            2'd1:    kick_we[i]  = wr_acc;
            2'd2:    tocnt_we[i] = wr_acc;
            default: stat_clr[i] = wr_acc && WDATA[0];
          endcase
        end
      end
    end
`ifdef WDT_PRESCALE_EN
    else if (wa == 9'h104) begin
      wr_ok  = 1'b1;
      pre_we = wr_acc;
    end
`endif
  end

  // Read address decode; unmapped addresses return zero data with SLVERR.
  always_comb begin
    ra        = ARADDR[8:0];
    rch       = ra[7:4];
    r_chan_ok = !ra[8] && ({28'b0, rch} < NCH) && (ra[1:0] == 2'b00);
    rd_ok     = 1'b0;
    rd_val    = 32'h0;
    if (r_chan_ok) begin
      rd_ok = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (rch == 4'(i)) begin
          case (ra[3:2])
            2'd0:    rd_val = 32'(en_q[i]);
            2'd1:    rd_val = 32'h0;
            2'd2:    rd_val = 32'(tocnt_q[i]);
            default: rd_val = 32'(wto_q[i]);
          endcase
        end
      end
    end else if (ra == 9'h100) begin
      rd_ok  = 1'b1;
      rd_val = 32'(wto_q);
    end
`ifdef WDT_PRESCALE_EN
    else if (ra == 9'h104) begin
      rd_ok  = 1'b1;
      rd_val = 32'(pre_q);
    end
`endif
  end

  // Bus FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (wr_acc)      state_d = StBrsp;
        else if (rd_acc) state_d = StRrsp;
      end
      StBrsp:  if (BREADY) state_d = StIdle;
      StRrsp:  if (RREADY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus FSM state and registered responses, captured at acceptance and held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bresp_q <= RespOkay;
      rresp_q <= RespOkay;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (wr_acc) bresp_q <= wr_ok ? RespOkay : RespSlvErr;
      if (rd_acc) begin
        rresp_q <= rd_ok ? RespOkay : RespSlvErr;
        rdata_q <= rd_ok ? rd_val : 32'h0;
      end
    end
  end

`ifdef WDT_PRESCALE_EN
  // Shared prescaler: one tick every PRE+1 clocks, restarted by any PRE write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= 16'h0;
      pre_cnt_q <= 16'h0;
    end else if (pre_we) begin
      pre_q     <= WDATA[15:0];
      pre_cnt_q <= 16'h0;
    end else if (tick) begin
      pre_cnt_q <= 16'h0;
    end else begin
      pre_cnt_q <= pre_cnt_q + 16'd1;
    end
  end
  assign tick = (pre_cnt_q == pre_q);
`else
  assign tick = 1'b1;
`endif

  // Channel registers and counters; any clearing event beats a coincident timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '0;
      wto_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        tocnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ctrl_we[i])  en_q[i]    <= WDATA[0];
        if (tocnt_we[i]) tocnt_q[i] <= WDATA[CNT_W-1:0];
        if (kick_we[i] || tocnt_we[i] || stat_clr[i] || !en_q[i]) begin
          cnt_q[i] <= '0;
        end else if (tick) begin
          if (cnt_q[i] < tocnt_q[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          else                       wto_q[i] <= 1'b1;
        end
        if (stat_clr[i]) wto_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wdt_multi_axil.sv
// Scoreboard bench for wdt_multi_axil (default build, NCH=4, CNT_W=32).
module tb_wdt_multi_axil;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic [3:0]  WTO;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  always #5 clk = ~clk;

  wdt_multi_axil #(.NCH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .WTO(WTO)
  );

  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input bit is_rd, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected response: is_rd=%0d resp=%0d data=0x%0h", is_rd, resp, data);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " kind"}, 32'(is_rd), 32'(e.is_rd));
      check({e.name, " resp"}, 32'(resp), 32'(e.resp));
      if (e.is_rd) check({e.name, " data"}, data, e.data);
    end
  endtask

  // Monitor: a response is consumed on the posedge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (BVALID && BREADY) pop_cmp(1'b0, BRESP, 32'h0);
    if (RVALID && RREADY) pop_cmp(1'b1, RRESP, RDATA);
  end

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  // Returns 1ns after the posedge that completes the B handshake.
  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input string name);
    int n;
    sb_q.push_back('{1'b0, resp, 32'h0, name});
    @(negedge clk);
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge clk); #1; n++; end
    if (!AWREADY) timeout({name, " aw"});
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(BVALID && BREADY) && n < 50) begin @(negedge clk); n++; end
    if (!(BVALID && BREADY)) timeout({name, " b"});
    @(posedge clk); #1;
  endtask

  task automatic axi_rd(input logic [31:0] addr, input logic [1:0] resp,
                        input logic [31:0] data, input string name);
    int n;
    sb_q.push_back('{1'b1, resp, data, name});
    @(negedge clk);
    ARADDR = addr; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); #1; n++; end
    if (!ARREADY) timeout({name, " ar"});
    @(posedge clk); #1;
    ARVALID = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(RVALID && RREADY) && n < 50) begin @(negedge clk); n++; end
    if (!(RVALID && RREADY)) timeout({name, " r"});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    rst = 1'b1;
    AWADDR = '0; WDATA = '0; ARADDR = '0;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    #3;
    // Reset state.
    check("rst awready", 32'(AWREADY), 32'h0);
    check("rst arready", 32'(ARREADY), 32'h0);
    check("rst bvalid",  32'(BVALID),  32'h0);
    check("rst rvalid",  32'(RVALID),  32'h0);
    check("rst rdata",   RDATA,        32'h0);
    check("rst wto",     32'(WTO),     32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ch1 TOCNT=5: timeout exactly 6 clocks after EN takes effect.
    axi_wr(32'h018, 32'd5, OKAY, "ch1 tocnt wr");
    axi_wr(32'h010, 32'd1, OKAY, "ch1 en wr");
    repeat (4) @(posedge clk); #1;
    check("ch1 wto at +5", 32'(WTO), 32'h0);
    @(posedge clk); #1;
    check("ch1 wto at +6", 32'(WTO), 32'h2);

    // Ch0 TOCNT=10, kicked every 8 clocks, then left to expire.
    axi_wr(32'h008, 32'd10, OKAY, "ch0 tocnt wr");
    axi_wr(32'h000, 32'd1, OKAY, "ch0 en wr");
    for (int i = 0; i < 13; i++) begin
      axi_wr(32'h004, 32'h0, OKAY, "ch0 kick");
      check("ch0 wto while kicked", 32'(WTO[0]), 32'h0);
      if (i < 12) repeat (6) @(posedge clk);
    end
    repeat (9) @(posedge clk); #1;
    check("ch0 wto at +10", 32'(WTO[0]), 32'h0);
    @(posedge clk); #1;
    check("ch0 wto at +11", 32'(WTO[0]), 32'h1);
    axi_rd(32'h00C, OKAY, 32'h1, "ch0 status rd");
    axi_rd(32'h100, OKAY, 32'h3, "summary rd");
    axi_rd(32'h004, OKAY, 32'h0, "ch0 kick rd");

    // W1C clears WTO[0]; counter restarts from 0.
    axi_wr(32'h00C, 32'h1, OKAY, "ch0 status w1c");
    check("ch0 wto after w1c", 32'(WTO), 32'h2);
    repeat (9) @(posedge clk); #1;
    check("ch0 wto restart +10", 32'(WTO[0]), 32'h0);
    @(posedge clk); #1;
    check("ch0 wto restart +11", 32'(WTO[0]), 32'h1);

    // Clearing EN keeps WTO.
    axi_wr(32'h000, 32'h0, OKAY, "ch0 en clr");
    repeat (3) @(posedge clk); #1;
    check("ch0 wto sticky after en=0", 32'(WTO[0]), 32'h1);
    axi_rd(32'h000, OKAY, 32'h0, "ch0 ctrl rd");

    // TOCNT=0 with EN=1 times out on the next tick.
    axi_wr(32'h030, 32'h1, OKAY, "ch3 en wr");
    check("ch3 tocnt0 wto", 32'(WTO), 32'hB);

    // Error paths: no side effects.
    axi_wr(32'h040, 32'hFFFF, SLVERR, "ch4 wr");
    axi_rd(32'h1F0, SLVERR, 32'h0, "0x1f0 rd");
    axi_wr(32'h100, 32'h0, SLVERR, "summary wr");
    axi_wr(32'h104, 32'h7, SLVERR, "pre wr unmapped");
    axi_rd(32'h104, SLVERR, 32'h0, "pre rd unmapped");
    check("wto after bad writes", 32'(WTO), 32'hB);
    axi_rd(32'h008, OKAY, 32'd10, "ch0 tocnt intact");
    axi_rd(32'h018, OKAY, 32'd5, "ch1 tocnt intact");

    // Simultaneous write and read with BREADY held low.
    BREADY = 1'b0;
    sb_q.push_back('{1'b0, OKAY, 32'h0, "arb wr"});
    sb_q.push_back('{1'b1, OKAY, 32'h55, "arb rd"});
    @(negedge clk);
    AWADDR = 32'h028; WDATA = 32'h55; ARADDR = 32'h028;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    #1;
    check("arb awready", 32'(AWREADY), 32'h1);
    check("arb arready low", 32'(ARREADY), 32'h0);
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arb bvalid held", 32'(BVALID), 32'h1);
      check("arb arready while B", 32'(ARREADY), 32'h0);
    end
    @(posedge clk); #1;
    BREADY = 1'b1;
    @(negedge clk); #1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); #1; n++; end
    if (!ARREADY) timeout("arb ar");
    @(posedge clk); #1;
    ARVALID = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(RVALID && RREADY) && n < 50) begin @(negedge clk); n++; end
    if (!(RVALID && RREADY)) timeout("arb r");
    @(posedge clk); #1;

    // Reset during RRSP with RREADY low aborts the read.
    RREADY = 1'b0;
    @(negedge clk);
    ARADDR = 32'h010; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); #1; n++; end
    if (!ARREADY) timeout("abort ar");
    @(posedge clk); #1;
    ARVALID = 1'b0;
    check("abort rvalid before rst", 32'(RVALID), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("abort rvalid in rst", 32'(RVALID), 32'h0);
    check("abort wto in rst", 32'(WTO), 32'h0);
    check("abort rdata in rst", RDATA, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    RREADY = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no response after abort", 32'(RVALID), 32'h0);
    end
    axi_rd(32'h010, OKAY, 32'h0, "ch1 ctrl after rst");
    axi_rd(32'h018, OKAY, 32'h0, "ch1 tocnt after rst");
    axi_rd(32'h100, OKAY, 32'h0, "summary after rst");

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
